// File: rtl/seq_signed_divider_if.sv
// seq_signed_divider_if: operand and result valid/ready channels of the sequential signed divider.
interface seq_signed_divider_if #(parameter int DW = 8, parameter int VW = 4);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW:0]   remainder;
  logic          div_by_zero;
  modport master (output in_valid, dividend, divisor, out_ready,
                  input in_ready, out_valid, quotient, remainder, div_by_zero);
  modport slave (input in_valid, dividend, divisor, out_ready,
                 output in_ready, out_valid, quotient, remainder, div_by_zero);
endinterface

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: restoring divider, signed DW-bit dividend by unsigned VW-bit divisor, one quotient bit per cycle.
module seq_signed_divider #(parameter int DW = 8, parameter int VW = 4) (
  input logic clk,
  input logic rst_n,
  seq_signed_divider_if.slave bus
);
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] CMAX = CW'(DW - 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic [DW-1:0] mag, q, quotient;
  logic [VW:0] p, remainder;
  logic [VW-1:0] dvs;
  logic [CW-1:0] cnt;
  logic neg, out_valid, div_by_zero;
  logic [VW:0] sh;
  logic ge;
  assign sh = {p[VW-1:0], mag[DW-1]};
  assign ge = sh >= {1'b0, dvs};
  // in_ready is gated by rst_n so it reads low while reset is held
  assign bus.in_ready = rst_n & (state == IDLE);
  assign bus.out_valid = out_valid;
  assign bus.quotient = quotient;
  assign bus.remainder = remainder;
  assign bus.div_by_zero = div_by_zero;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mag <= '0;
      q <= '0;
      p <= '0;
      dvs <= '0;
      cnt <= '0;
      neg <= 1'b0;
      out_valid <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          neg <= bus.dividend[DW-1];
          mag <= bus.dividend[DW-1] ? -bus.dividend : bus.dividend;
          dvs <= bus.divisor;
          p <= '0;
          q <= '0;
          cnt <= CMAX;
          if (bus.divisor == '0) begin
            quotient <= '0;
            remainder <= '0;
            div_by_zero <= 1'b1;
            out_valid <= 1'b1;
            state <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          p <= ge ? sh - {1'b0, dvs} : sh;
          q <= {q[DW-2:0], ge};
          mag <= mag << 1;
          cnt <= cnt - 1'b1;
          state <= (cnt == '0) ? FIX : CALC;
        end
        FIX: begin
          quotient <= neg ? -q : q;
          remainder <= neg ? -p : p;
          div_by_zero <= 1'b0;
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (bus.out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: directed vector table, corner sequences and random ops against a plain-arithmetic model.
module tb_seq_signed_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  seq_signed_divider_if #(.DW(8), .VW(4)) bus ();
  seq_signed_divider #(.DW(8), .VW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    int         stall;
    logic       intrude;
    logic [7:0] q;
    logic [4:0] r;
    logic       z;
    int         lat;
  } vec_t;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model(input logic [7:0] a, input logic [3:0] b,
                                output logic [7:0] q, output logic [4:0] r, output logic z);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'(b);
    if (sb == 0) begin
      q = '0; r = '0; z = 1'b1;
    end else begin
      q = 8'(sa / sb); r = 5'(sa % sb); z = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic op(input logic [7:0] a, input logic [3:0] b, input int stall, input logic intrude,
                    output logic [7:0] q, output logic [4:0] r, output logic z, output int lat);
    int n;
    n = 0;
    while (!bus.in_ready && n < 40) begin tick(); n++; end
    check("in_ready_before_op", 32'(bus.in_ready), 32'd1);
    bus.dividend = a;
    bus.divisor = b;
    bus.in_valid = 1'b1;
    bus.out_ready = (stall == 0);
    tick();
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 40) begin tick(); n++; end
    check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    lat = n;
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
    for (int i = 0; i < stall; i++) begin
      if (intrude) begin
        bus.dividend = 8'd20; bus.divisor = 4'd5; bus.in_valid = 1'b1;
      end
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_q_stable", 32'(bus.quotient), 32'(q));
      check("stall_r_stable", 32'(bus.remainder), 32'(r));
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("post_hs_valid", 32'(bus.out_valid), 32'd0);
    check("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    vec_t tbl[$];
    logic [7:0] q, eq;
    logic [4:0] r, er;
    logic z, ez;
    int lat;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    tbl.push_back('{8'd100, 4'd7, 0, 1'b0, 8'h0E, 5'h02, 1'b0, 10});
    tbl.push_back('{8'h9C, 4'd7, 0, 1'b0, 8'hF2, 5'h1E, 1'b0, 10});
    tbl.push_back('{8'h80, 4'd1, 0, 1'b0, 8'h80, 5'h00, 1'b0, 10});
    tbl.push_back('{8'd127, 4'd15, 0, 1'b0, 8'h08, 5'h07, 1'b0, 10});
    tbl.push_back('{8'd50, 4'd0, 0, 1'b0, 8'h00, 5'h00, 1'b1, 1});
    tbl.push_back('{8'd9, 4'd3, 0, 1'b0, 8'h03, 5'h00, 1'b0, 10});
    tbl.push_back('{8'd45, 4'd4, 5, 1'b1, 8'h0B, 5'h01, 1'b0, 10});
    tbl.push_back('{8'd20, 4'd5, 0, 1'b0, 8'h04, 5'h00, 1'b0, 10});
    tbl.push_back('{8'd0, 4'd5, 0, 1'b0, 8'h00, 5'h00, 1'b0, 10});
    tbl.push_back('{8'd127, 4'd1, 0, 1'b0, 8'h7F, 5'h00, 1'b0, 10});
    tbl.push_back('{8'hFF, 4'd15, 0, 1'b0, 8'h00, 5'h1F, 1'b0, 10});
    tbl.push_back('{8'h80, 4'd15, 0, 1'b0, 8'hF8, 5'h18, 1'b0, 10});

    tick(); tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    tick();

    foreach (tbl[i]) begin
      op(tbl[i].a, tbl[i].b, tbl[i].stall, tbl[i].intrude, q, r, z, lat);
      check($sformatf("vec%0d_q", i), 32'(q), 32'(tbl[i].q));
      check($sformatf("vec%0d_r", i), 32'(r), 32'(tbl[i].r));
      check($sformatf("vec%0d_dbz", i), 32'(z), 32'(tbl[i].z));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
    end

    // reset four edges into the calculation of 77/3
    bus.dividend = 8'd77; bus.divisor = 4'd3; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("midrst_rel_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      check("midrst_no_result", 32'(bus.out_valid), 32'd0);
      tick();
    end
    op(8'd77, 4'd3, 0, 1'b0, q, r, z, lat);
    check("midrst_q", 32'(q), 32'd25);
    check("midrst_r", 32'(r), 32'd2);
    check("midrst_dbz", 32'(z), 32'd0);

    for (int i = 0; i < 200; i++) begin
      logic [7:0] a;
      logic [3:0] b;
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      model(a, b, eq, er, ez);
      op(a, b, int'($urandom_range(0, 2)), 1'b0, q, r, z, lat);
      check($sformatf("rnd %0d/%0d q", $signed(a), b), 32'(q), 32'(eq));
      check($sformatf("rnd %0d/%0d r", $signed(a), b), 32'(r), 32'(er));
      check($sformatf("rnd %0d/%0d dbz", $signed(a), b), 32'(z), 32'(ez));
      check($sformatf("rnd %0d/%0d lat", $signed(a), b), 32'(lat), ez ? 32'd1 : 32'd10);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Multi-cycle restoring divider; the inverse operation of the team's Wallace-tree multiplier.
- Divides a signed two's-complement dividend (full product width, DW bits) by an unsigned divisor (VW bits).
- Returns a truncated quotient and a remainder that carries the dividend's sign.
- Sits downstream of the multiplier datapath. Used for scaling and normalisation. Valid/ready handshake on both sides.

Parameters:
DW, 8, dividend and quotient width (signed)
VW, 4, divisor width (unsigned); remainder width is VW+1 (signed)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands (high only in IDLE)
dividend  input  DW  signed dividend
divisor  input  VW  unsigned divisor
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
quotient  output  DW  signed quotient, truncated toward zero
remainder  output  VW+1  signed remainder, same sign as dividend or zero
div_by_zero  output  1  divisor was zero for this result

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1 once reset is released; out_valid=0; quotient=0; remainder=0; div_by_zero=0; all internal registers cleared. Reset mid-operation aborts the operation. No result is produced for it.
- Acceptance: a rising edge with in_valid && in_ready latches dividend and divisor. in_valid while not in IDLE is ignored; the source must hold it.
- States:
  - IDLE: on acceptance, go to CALC if divisor != 0, else go to DONE with div_by_zero=1, quotient=0, remainder=0.
  - CALC: DW cycles, one quotient bit per cycle, MSB first. Operand is the magnitude of the dividend, held as DW-bit unsigned, so -2^(DW-1) maps to 2^(DW-1). Each cycle: partial remainder (VW+1 bits) = {partial[VW-1:0], next magnitude bit}. If partial >= divisor, subtract the divisor and the quotient bit is 1; else the quotient bit is 0. A bit counter runs DW-1 down to 0. Leave after the counter reaches 0.
  - FIX: one cycle. If the dividend is negative, two's-complement negate both quotient and remainder. Register the outputs, then go to DONE.
  - DONE: out_valid=1 and outputs stable. On out_valid && out_ready, go to IDLE and drop out_valid. The outputs keep their values until the next result is written.
- Latency from the acceptance edge to out_valid high:
  - Normal: DW+2 edges (10 for DW=8).
  - Divide-by-zero: 1 edge.
- Throughput: one operation per DW+3 cycles minimum (out_ready held high). in_ready is low from acceptance until the cycle after the result handshake.
- Width rules:
  - Quotient magnitude is at most 2^(DW-1). For -128/1 the quotient is 0x80 (−128), the correct wrap-free result. For +127/1 it is 0x7F.
  - Remainder magnitude is at most 2^VW − 2, so it always fits in VW+1 signed bits.
  - No overflow flag is needed.
- Simultaneous events:
  - out_ready arriving in the same cycle out_valid rises completes the handshake on that edge.
  - in_valid held during DONE is not accepted until IDLE.
- Divisor of 1: quotient equals the dividend, remainder is 0. Dividend of 0: quotient 0, remainder 0, div_by_zero=0.

Test Plan:
- 100 / 7, out_ready=1 -> out_valid 10 edges after acceptance; quotient=14 (0x0E); remainder=2 (5'b00010); div_by_zero=0.
- −100 (0x9C) / 7 -> quotient=−14 (0xF2); remainder=−2 (5'b11110); div_by_zero=0.
- −128 (0x80) / 1 -> quotient=0x80, remainder=0. Also 127 / 15 -> quotient=8, remainder=7.
- 50 / 0 -> out_valid after 1 edge; div_by_zero=1; quotient=0; remainder=0. Next op 9/3 -> quotient=3, remainder=0, div_by_zero=0.
- Backpressure: 45 / 4 with out_ready=0 for 5 cycles after out_valid -> quotient=11 and remainder=1 held stable; in_ready=0; a second in_valid (20/5) is not accepted. After out_ready=1 -> IDLE, then 20/5 is accepted and gives quotient=4, remainder=0.
- Reset mid-operation: assert rst_n=0 four edges into CALC of 77/3 -> out_valid=0 and in_ready=0 while in reset. After release: in_ready=1, no spurious result. Then 77/3 -> quotient=25, remainder=2.
